// File: rtl/sb_init_pkg.sv
// Shared definitions for the sideband init handshake: message codes, FSM
// state encodings and the timeout counter width helper.
package sb_init_pkg;

  localparam int unsigned MSG_NONE         = 0;
  localparam int unsigned MSG_OUT_OF_RESET = 1;
  localparam int unsigned MSG_DONE_REQ     = 2;
  localparam int unsigned MSG_DONE_RESP    = 3;

  typedef enum logic [2:0] {
    TX_IDLE       = 3'd0,
    TX_PATTERN    = 3'd1,
    TX_WAIT_DET   = 3'd2,
    TX_SEND_OOR   = 3'd3,
    TX_SEND_DREQ  = 3'd4,
    TX_WAIT_DRESP = 3'd5,
    TX_DONE       = 3'd6,
    TX_ERROR      = 3'd7
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE       = 3'd0,
    RX_WAIT_OOR   = 3'd1,
    RX_WAIT_DREQ  = 3'd2,
    RX_SEND_DRESP = 3'd3,
    RX_DONE       = 3'd4
  } rx_state_t;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sb_timeout_counter.sv
// Free-running wait timer: counts while enabled, flags expiry on its last
// count and wraps back to zero.
module sb_timeout_counter
  import sb_init_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned   CW   = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_expired;

  assign w_expired = i_enable && !i_clear && (r_count == LAST);
  assign o_expired = w_expired;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear || w_expired) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/sbinit_handshake_engine.sv
// SBINIT handshake: TX FSM drives pattern and OOR/DONE_REQ, RX FSM answers the
// partner's DONE_REQ; both share one message issue slot paced by SB busy.
module sbinit_handshake_engine
  import sb_init_pkg::*;
#(
  parameter int unsigned SB_MSG_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 8000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_sbinit_en,
  input  logic                    i_start_pattern_done,
  input  logic                    i_pattern_detected,
  input  logic                    i_sb_busy,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_sb_msg,
  input  logic                    i_msg_valid,
  output logic                    o_start_pattern_req,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_sb_msg,
  output logic                    o_tx_msg_valid,
  output logic                    o_sbinit_end,
  output logic                    o_sbinit_error
);

  localparam logic [SB_MSG_WIDTH-1:0] C_NONE  = SB_MSG_WIDTH'(MSG_NONE);
  localparam logic [SB_MSG_WIDTH-1:0] C_OOR   = SB_MSG_WIDTH'(MSG_OUT_OF_RESET);
  localparam logic [SB_MSG_WIDTH-1:0] C_DREQ  = SB_MSG_WIDTH'(MSG_DONE_REQ);
  localparam logic [SB_MSG_WIDTH-1:0] C_DRESP = SB_MSG_WIDTH'(MSG_DONE_RESP);
  localparam int unsigned             RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]           C_MAXR  = RW'(MAX_RETRY);

  tx_state_t r_tx_state, w_tx_next;
  rx_state_t r_rx_state, w_rx_next;

  logic [RW-1:0]           r_det_retry, r_dreq_retry;
  logic                    r_det_latched, r_dresp_latched, r_busy_q;
  logic                    r_wait_fall, r_owner_rx, r_tx_issued, r_rx_issued;
  logic                    w_busy_fall, w_tx_fall, w_rx_fall;
  logic                    w_msg_oor, w_msg_dreq, w_msg_dresp;
  logic                    w_tx_req, w_rx_req, w_issue, w_in_wait, w_expired;
  logic [SB_MSG_WIDTH-1:0] w_issue_code;

  assign w_msg_oor   = i_msg_valid && (i_decoded_sb_msg == C_OOR);
  assign w_msg_dreq  = i_msg_valid && (i_decoded_sb_msg == C_DREQ);
  assign w_msg_dresp = i_msg_valid && (i_decoded_sb_msg == C_DRESP);

  // Only a fall that follows our own issue advances the issuing FSM.
  assign w_busy_fall = r_busy_q && !i_sb_busy;
  assign w_tx_fall   = w_busy_fall && r_wait_fall && !r_owner_rx;
  assign w_rx_fall   = w_busy_fall && r_wait_fall && r_owner_rx;

  assign w_tx_req = ((r_tx_state == TX_SEND_OOR) || (r_tx_state == TX_SEND_DREQ)) && !r_tx_issued;
  assign w_rx_req = (r_rx_state == RX_SEND_DRESP) && !r_rx_issued && (r_tx_state != TX_ERROR);
  assign w_issue  = i_sbinit_en && (w_tx_req || w_rx_req) && !i_sb_busy && !r_wait_fall;

  assign w_issue_code = w_rx_req                    ? C_DRESP :
                        (r_tx_state == TX_SEND_OOR) ? C_OOR   : C_DREQ;

  assign w_in_wait = (r_tx_state == TX_WAIT_DET) || (r_tx_state == TX_WAIT_DRESP);

  sb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (!w_in_wait || !i_sbinit_en),
    .i_enable (w_in_wait),
    .o_expired(w_expired)
  );

  always_comb begin
    w_tx_next = r_tx_state;
    if (!i_sbinit_en) begin
      w_tx_next = TX_IDLE;
    end else begin
      case (r_tx_state)
        TX_IDLE:       w_tx_next = TX_PATTERN;
        TX_PATTERN:    if (i_start_pattern_done) w_tx_next = TX_WAIT_DET;
        TX_WAIT_DET: begin
          if (i_pattern_detected || r_det_latched) w_tx_next = TX_SEND_OOR;
          else if (w_expired) w_tx_next = (r_det_retry == C_MAXR) ? TX_ERROR : TX_PATTERN;
        end
        TX_SEND_OOR:   if (w_tx_fall) w_tx_next = TX_SEND_DREQ;
        TX_SEND_DREQ:  if (w_tx_fall) w_tx_next = TX_WAIT_DRESP;
        TX_WAIT_DRESP: begin
          if (w_msg_dresp || r_dresp_latched) w_tx_next = TX_DONE;
          else if (w_expired) w_tx_next = (r_dreq_retry == C_MAXR) ? TX_ERROR : TX_SEND_DREQ;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    if (!i_sbinit_en) begin
      w_rx_next = RX_IDLE;
    end else begin
      case (r_rx_state)
        RX_IDLE:     w_rx_next = RX_WAIT_OOR;
        RX_WAIT_OOR: begin
          if (w_msg_dreq) w_rx_next = RX_SEND_DRESP;
          else if (w_msg_oor) w_rx_next = RX_WAIT_DREQ;
        end
        RX_WAIT_DREQ:  if (w_msg_dreq) w_rx_next = RX_SEND_DRESP;
        RX_SEND_DRESP: if (w_rx_fall) w_rx_next = RX_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy_q <= 1'b0;
    end else begin
      r_busy_q <= i_sb_busy;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_state          <= TX_IDLE;
      r_rx_state          <= RX_IDLE;
      r_det_retry         <= '0;
      r_dreq_retry        <= '0;
      r_det_latched       <= 1'b0;
      r_dresp_latched     <= 1'b0;
      r_wait_fall         <= 1'b0;
      r_owner_rx          <= 1'b0;
      r_tx_issued         <= 1'b0;
      r_rx_issued         <= 1'b0;
      o_start_pattern_req <= 1'b0;
      o_encoded_sb_msg    <= C_NONE;
      o_tx_msg_valid      <= 1'b0;
      o_sbinit_end        <= 1'b0;
      o_sbinit_error      <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_rx_state <= w_rx_next;
      if (!i_sbinit_en) begin
        r_det_retry     <= '0;
        r_dreq_retry    <= '0;
        r_det_latched   <= 1'b0;
        r_dresp_latched <= 1'b0;
        r_wait_fall     <= 1'b0;
        r_owner_rx      <= 1'b0;
        r_tx_issued     <= 1'b0;
        r_rx_issued     <= 1'b0;
      end else begin
        // A detection seen while still sending the pattern is held for WAIT_DET.
        if ((r_tx_state == TX_PATTERN) && i_pattern_detected) r_det_latched <= 1'b1;
        else if (r_tx_state == TX_WAIT_DET) r_det_latched <= 1'b0;
        if ((r_tx_state == TX_WAIT_DET) && (w_tx_next == TX_PATTERN))
          r_det_retry <= r_det_retry + 1'b1;
        if ((r_tx_state == TX_WAIT_DRESP) && (w_tx_next == TX_SEND_DREQ))
          r_dreq_retry <= r_dreq_retry + 1'b1;
        if (((r_tx_state == TX_SEND_DREQ) || (r_tx_state == TX_WAIT_DRESP)) && w_msg_dresp)
          r_dresp_latched <= 1'b1;
        if (w_issue) begin
          r_wait_fall <= 1'b1;
          r_owner_rx  <= w_rx_req;
          if (w_rx_req) r_rx_issued <= 1'b1;
          else          r_tx_issued <= 1'b1;
        end else if (w_busy_fall && r_wait_fall) begin
          r_wait_fall <= 1'b0;
          if (r_owner_rx) r_rx_issued <= 1'b0;
          else            r_tx_issued <= 1'b0;
        end
      end
      o_start_pattern_req <= (w_tx_next == TX_PATTERN);
      o_tx_msg_valid      <= w_issue;
      o_encoded_sb_msg    <= w_issue ? w_issue_code : C_NONE;
      o_sbinit_end        <= (w_tx_next == TX_DONE) && (w_rx_next == RX_DONE);
      o_sbinit_error      <= (w_tx_next == TX_ERROR);
    end
  end

endmodule

// File: doc/sbinit_handshake_engine.md
SBINIT_HANDSHAKE_ENGINE -- requirements
Module: sbinit_handshake_engine

Interface
REQ-001 SHALL have parameter SB_MSG_WIDTH, default 4: width of encoded/decoded sideband message codes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 8000: cycles to wait for partner pattern detection or a partner response before a retry.
REQ-003 SHALL have parameter MAX_RETRY, default 3: pattern retries allowed before error.
REQ-004 SHALL have i_clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have i_sbinit_en  input  1  level enable from LTSM; low aborts the sequence.
REQ-007 SHALL have i_start_pattern_done  input  1  pulse from SB: 64UI pattern burst finished.
REQ-008 SHALL have i_pattern_detected  input  1  pulse from SB: partner pattern detected.
REQ-009 SHALL have i_sb_busy  input  1  high while SB transmits a message.
REQ-010 SHALL have i_decoded_sb_msg  input  SB_MSG_WIDTH  partner message code, valid when i_msg_valid.
REQ-011 SHALL have i_msg_valid  input  1  one-cycle strobe qualifying i_decoded_sb_msg.
REQ-012 SHALL have o_start_pattern_req  output  1  level request to SB to send the pattern.
REQ-013 SHALL have o_encoded_sb_msg  output  SB_MSG_WIDTH  message code to SB; MSG_NONE when not valid.
REQ-014 SHALL have o_tx_msg_valid  output  1  one-cycle issue strobe.
REQ-015 SHALL have o_sbinit_end  output  1  level: sequence complete.
REQ-016 SHALL have o_sbinit_error  output  1  level: retries exhausted.

Function
REQ-017 Message codes SHALL be MSG_NONE=0, MSG_OUT_OF_RESET=1, MSG_DONE_REQ=2, MSG_DONE_RESP=3; other codes on input SHALL be ignored.
REQ-018 TX FSM states SHALL be IDLE, PATTERN, WAIT_DET, SEND_OOR, SEND_DREQ, WAIT_DRESP, DONE, ERROR.
REQ-019 IDLE->PATTERN when i_sbinit_en=1; o_start_pattern_req SHALL be high in PATTERN only.
REQ-020 PATTERN->WAIT_DET on i_start_pattern_done; the timeout counter SHALL be cleared on entry to WAIT_DET.
REQ-021 WAIT_DET->SEND_OOR on i_pattern_detected; if the counter reaches TIMEOUT_CYCLES-1 without detection, retry count SHALL increment and FSM SHALL return to PATTERN, or go to ERROR when retries already equal MAX_RETRY.
REQ-022 A pattern detection arriving in PATTERN SHALL be latched and honoured on entry to WAIT_DET (zero wait).
REQ-023 SEND_OOR, SEND_DREQ SHALL each request one message; state SHALL advance on the falling edge of i_sb_busy (i_sb_busy registered, current 0, previous 1) following its own issue.
REQ-024 WAIT_DRESP->DONE on received MSG_DONE_RESP; a timeout in WAIT_DRESP SHALL re-enter SEND_DREQ without consuming a retry more than MAX_RETRY times, then ERROR.
REQ-025 RX FSM states SHALL be IDLE, WAIT_OOR, WAIT_DREQ, SEND_DRESP, DONE; advancing on MSG_OUT_OF_RESET, MSG_DONE_REQ, then busy falling edge after issuing MSG_DONE_RESP.
REQ-026 MSG_DONE_REQ received before MSG_OUT_OF_RESET SHALL be treated as implying OOR (skip to SEND_DRESP).
REQ-027 Issue rule: o_tx_msg_valid=1 for exactly one cycle when a request is pending, i_sb_busy=0, and no earlier issue awaits its busy falling edge.
REQ-028 Arbitration: simultaneous TX and RX requests SHALL grant RX; TX request SHALL be held and issued after RX busy falling edge.
REQ-029 o_sbinit_end SHALL be 1 when both FSMs are in DONE, held until i_sbinit_en=0.
REQ-030 o_sbinit_error SHALL be held until i_sbinit_en=0; no messages or pattern requests SHALL issue in ERROR.
REQ-031 i_sbinit_en=0 in any state SHALL return both FSMs to IDLE next cycle, clear counters and the detection latch, and drop all outputs.

Reset
REQ-032 While i_rst=1 all outputs SHALL be 0, o_encoded_sb_msg MSG_NONE, FSMs IDLE, counters and registered busy 0, asynchronously.
REQ-033 Deassertion of i_rst with i_sbinit_en=1 SHALL start PATTERN on the first following clock edge.

Structure
REQ-034 Message codes, FSM state encodings and counter width ($clog2(TIMEOUT_CYCLES)) SHALL live in shared package sb_init_pkg.
REQ-035 Timeout/retry counting SHALL be a sub-module sb_timeout_counter (clear, enable, expired outputs).

Verification
REQ-036 En=1, pattern_done at cycle 5, detected at 10, partner OOR/DONE_REQ/DONE_RESP prompt, busy 2-cycle pulses -> o_sbinit_end=1 within 40 cycles, exactly three messages issued.
REQ-037 TIMEOUT_CYCLES=16, MAX_RETRY=2, no detection -> three o_start_pattern_req assertions then o_sbinit_error=1 at ~cycle 3x(16+pattern) .
REQ-038 TX SEND_DREQ and RX SEND_DRESP pending same cycle -> code 3 issued first, code 2 issued after busy falls, never both valid together.
REQ-039 Partner sends DONE_REQ without OOR -> DONE_RESP issued, RX reaches DONE.
REQ-040 En dropped while busy=1 in SEND_OOR -> next cycle all outputs 0; en reasserted -> fresh PATTERN, retry count 0.
REQ-041 Async i_rst pulse mid-WAIT_DRESP (between clock edges) -> outputs 0 immediately, no message issued after release until protocol restarts.
